// File: rtl/sop_unmask_collector.sv
// sop_unmask_collector: recombines a two-share masked monomial vector into its
// unmasked form over several cycles, then flags results whose product bits do
// not match the AND of their linear bits.
//
// Vector bit map (shares and mono_out):
//   [14]a [13]b [12]c [11]d [10]ab [9]ac [8]ad [7]bc [6]bd [5]cd
//   [4]abc [3]abd [2]acd [1]bcd [0]abcd
module sop_unmask_collector #(
  parameter int unsigned CHECK_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] share0_in,
  input  logic [14:0] share1_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] mono_out,
  output logic [3:0]  nibble_out,
  output logic        check_err,
  input  logic        err_clr,
  output logic [15:0] err_count
);

  localparam bit CheckEn = (CHECK_EN != 0);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad0 = 3'd1;
  localparam logic [2:0] StMix1  = 3'd2;
  localparam logic [2:0] StCheck = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [14:0] r0_q, r1_q, acc_q;
  logic [14:0] mono_q;
  logic        check_err_q;
  logic [15:0] err_count_q;

  logic        a, b, c, d;
  logic [10:0] prod_exp;
  logic        err_now;

  // Products implied by the linear bits of the recombined vector.
  always_comb begin
    a = acc_q[14];
    b = acc_q[13];
    c = acc_q[12];
    d = acc_q[11];
    prod_exp = {a & b, a & c, a & d, b & c, b & d, c & d,
                a & b & c, a & b & d, a & c & d, b & c & d,
                a & b & c & d};
    err_now = CheckEn && (|(prod_exp ^ acc_q[10:0]));
  end

  // Next-state sequencing; HOLD waits for the consumer handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StLoad0;
      StLoad0: state_d = StMix1;
      StMix1:  state_d = StCheck;
      StCheck: state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Share capture and recombination: shares enter the accumulator in separate
  // cycles and each share register is wiped once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q        <= '0;
      r1_q        <= '0;
      acc_q       <= '0;
      mono_q      <= '0;
      check_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            r0_q <= share0_in;
            r1_q <= share1_in;
          end
        end
        StLoad0: begin
          acc_q <= r0_q;
          r0_q  <= '0;
        end
        StMix1: begin
          acc_q <= acc_q ^ r1_q;
          r1_q  <= '0;
        end
        StCheck: begin
          mono_q      <= acc_q;
          check_err_q <= err_now;
          acc_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Saturating error counter; a clear beats a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (err_clr) begin
      err_count_q <= '0;
    end else if ((state_q == StCheck) && err_now && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  // Output decode.
  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StHold);
    mono_out   = mono_q;
    nibble_out = mono_q[14:11];
    check_err  = check_err_q;
    err_count  = err_count_q;
  end

endmodule

// File: tb/tb_sop_unmask_collector.sv
// Bench for sop_unmask_collector: table of share pairs with expected unmasked
// results, a scoreboard queue, and hand sequences for back-pressure, reset in
// flight, counter saturation and clear priority. A second instance with the
// consistency check disabled runs on the same stimulus.
module tb_sop_unmask_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] share0_in;
  logic [14:0] share1_in;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] mono_out;
  logic [3:0]  nibble_out;
  logic        check_err;
  logic        err_clr;
  logic [15:0] err_count;

  logic        nc_in_ready;
  logic        nc_out_valid;
  logic [14:0] nc_mono_out;
  logic [3:0]  nc_nibble_out;
  logic        nc_check_err;
  logic [15:0] nc_err_count;

  sop_unmask_collector #(.CHECK_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .share0_in  (share0_in),
    .share1_in  (share1_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mono_out   (mono_out),
    .nibble_out (nibble_out),
    .check_err  (check_err),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  sop_unmask_collector #(.CHECK_EN(0)) dut_nc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (nc_in_ready),
    .share0_in  (share0_in),
    .share1_in  (share1_in),
    .out_valid  (nc_out_valid),
    .out_ready  (out_ready),
    .mono_out   (nc_mono_out),
    .nibble_out (nc_nibble_out),
    .check_err  (nc_check_err),
    .err_clr    (err_clr),
    .err_count  (nc_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] s0;
    logic [14:0] s1;
    logic [14:0] mono;
    logic [3:0]  nib;
    logic        err;
  } vec_t;

  typedef struct {
    logic [14:0] mono;
    logic [3:0]  nib;
    logic        err;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare against both instances.
  task automatic collect_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("mono_out", {17'd0, mono_out}, {17'd0, e.mono});
    chk("nibble_out", {28'd0, nibble_out}, {28'd0, e.nib});
    chk("check_err", {31'd0, check_err}, {31'd0, e.err});
    chk("err_count", {16'd0, err_count}, {16'd0, exp_cnt});
    chk("nc_out_valid", {31'd0, nc_out_valid}, 32'd1);
    chk("nc_mono_out", {17'd0, nc_mono_out}, {17'd0, e.mono});
    chk("nc_check_err", {31'd0, nc_check_err}, 32'd0);
    chk("nc_err_count", {16'd0, nc_err_count}, 32'd0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One full transaction; clr raises err_clr in the CHECK cycle.
  task automatic run_txn(input logic [14:0] s0, input logic [14:0] s1,
                         input logic [14:0] emono, input logic [3:0] enib,
                         input logic eerr, input bit clr);
    wait_ready();
    in_valid  = 1'b1;
    share0_in = s0;
    share1_in = s1;
    sb.push_back('{mono: emono, nib: enib, err: eerr});
    tick();                       // acceptance edge -> LOAD0
    in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    tick();                       // -> MIX1
    chk("lat1_valid", {31'd0, out_valid}, 32'd0);
    tick();                       // -> CHECK
    chk("lat2_valid", {31'd0, out_valid}, 32'd0);
    if (clr) err_clr = 1'b1;
    tick();                       // -> HOLD
    err_clr = 1'b0;
    if (clr) exp_cnt = 16'd0;
    else if (eerr && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    chk("lat3_valid", {31'd0, out_valid}, 32'd1);
    collect_result();
    out_ready = 1'b1;
    tick();                       // handshake -> IDLE
    out_ready = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit stable;
    bit saw_valid;

    vecs[0] = '{s0: 15'h1234, s1: 15'h4910, mono: 15'h5B24, nib: 4'hB, err: 1'b0};
    vecs[1] = '{s0: 15'h7FFF, s1: 15'h0000, mono: 15'h7FFF, nib: 4'hF, err: 1'b0};
    vecs[2] = '{s0: 15'h0400, s1: 15'h0000, mono: 15'h0400, nib: 4'h0, err: 1'b1};
    vecs[3] = '{s0: 15'h0000, s1: 15'h0000, mono: 15'h0000, nib: 4'h0, err: 1'b0};
    vecs[4] = '{s0: 15'h4000, s1: 15'h0000, mono: 15'h4000, nib: 4'h8, err: 1'b0};
    vecs[5] = '{s0: 15'h1234, s1: 15'h7634, mono: 15'h6400, nib: 4'hC, err: 1'b0};
    vecs[6] = '{s0: 15'h7800, s1: 15'h0000, mono: 15'h7800, nib: 4'hF, err: 1'b1};
    vecs[7] = '{s0: 15'h5555, s1: 15'h2AAA, mono: 15'h7FFF, nib: 4'hF, err: 1'b0};
    vecs[8] = '{s0: 15'h0001, s1: 15'h0000, mono: 15'h0001, nib: 4'h0, err: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    share0_in = '0;
    share1_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mono", {17'd0, mono_out}, 32'd0);
    chk("rst_nibble", {28'd0, nibble_out}, 32'd0);
    chk("rst_check_err", {31'd0, check_err}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].s0, vecs[i].s1, vecs[i].mono, vecs[i].nib, vecs[i].err, 1'b0);
    end

    // Back-pressure: result held 10 cycles, in_valid high throughout.
    wait_ready();
    in_valid  = 1'b1;
    share0_in = 15'h1234;
    share1_in = 15'h4910;
    sb.push_back('{mono: 15'h5B24, nib: 4'hB, err: 1'b0});
    tick();
    share0_in = 15'h5555;
    share1_in = 15'h2AAA;
    repeat (3) tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    collect_result();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_mono", {17'd0, mono_out}, 32'h5B24);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back('{mono: 15'h7FFF, nib: 4'hF, err: 1'b0});
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", {31'd0, in_ready}, 32'd0);
    repeat (2) begin
      tick();
      chk("bp_second_lat", {31'd0, out_valid}, 32'd0);
    end
    tick();
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    collect_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while in MIX1 discards the transaction.
    wait_ready();
    in_valid  = 1'b1;
    share0_in = 15'h7FFF;
    share1_in = 15'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_cnt = 16'd0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_mono", {17'd0, mono_out}, 32'd0);
    chk("mid_rst_nibble", {28'd0, nibble_out}, 32'd0);
    chk("mid_rst_check_err", {31'd0, check_err}, 32'd0);
    chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("mid_rst_no_pulse", {31'd0, saw_valid}, 32'd0);
    run_txn(15'h1234, 15'h4910, 15'h5B24, 4'hB, 1'b0, 1'b0);

    // Saturation: preset the counter just below the ceiling.
    tick();
    force dut.err_count_q = 16'hFFFE;
    #2;
    release dut.err_count_q;
    exp_cnt = 16'hFFFE;
    chk("preset_err_count", {16'd0, err_count}, 32'h0000FFFE);
    run_txn(15'h0400, 15'h0000, 15'h0400, 4'h0, 1'b1, 1'b0);
    chk("sat_reach", {16'd0, err_count}, 32'h0000FFFF);
    run_txn(15'h0400, 15'h0000, 15'h0400, 4'h0, 1'b1, 1'b0);
    stable = (err_count == 16'hFFFF);
    chk("sat_hold", {31'd0, stable}, 32'd1);
    run_txn(15'h0001, 15'h0000, 15'h0001, 4'h0, 1'b1, 1'b1);
    chk("clr_wins", {16'd0, err_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sop_unmask_collector.md
SOP_UNMASK_COLLECTOR -- requirements
Module: sop_unmask_collector

Interface
REQ-001 SHALL have parameter CHECK_EN, default 1, meaning monomial consistency check enabled (0 = check_err forced 0, err_count never increments).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  share pair present.
REQ-005 SHALL have port in_ready  output  1  block can accept a share pair.
REQ-006 SHALL have port share0_in  input  15  domain-0 monomial share vector.
REQ-007 SHALL have port share1_in  input  15  domain-1 monomial share vector.
REQ-008 SHALL have port out_valid  output  1  result held on outputs.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port mono_out  output  15  unmasked monomial vector.
REQ-011 SHALL have port nibble_out  output  4  unmasked {a,b,c,d} = mono_out[14:11].
REQ-012 SHALL have port check_err  output  1  result inconsistent with its linear bits.
REQ-013 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-014 SHALL have port err_count  output  16  saturating count of inconsistent results.

Function
REQ-015 Vector bit map, both shares and mono_out: [14]a [13]b [12]c [11]d [10]ab [9]ac [8]ad [7]bc [6]bd [5]cd [4]abc [3]abd [2]acd [1]bcd [0]abcd.
REQ-016 FSM states SHALL be IDLE, LOAD0, MIX1, CHECK, HOLD; in_ready = 1 only in IDLE.
REQ-017 IDLE: on in_valid & in_ready, register share0_in->r0 and share1_in->r1, go to LOAD0; otherwise stay.
REQ-018 LOAD0: acc <= r0, r0 <= 0, go to MIX1 (shares never combined combinationally in the same cycle they are captured).
REQ-019 MIX1: acc <= acc ^ r1, r1 <= 0, go to CHECK.
REQ-020 CHECK: register mono_out <= acc, check_err <= CHECK_EN & (any acc[10:0] bit != AND of its constituent acc[14:11] bits), acc <= 0, go to HOLD.
REQ-021 HOLD: out_valid = 1; mono_out, nibble_out, check_err stable until out_valid & out_ready; on that edge go to IDLE.
REQ-022 Latency: out_valid SHALL rise exactly 3 clocks after the acceptance edge; minimum 4 clocks between acceptances (no IDLE bypass).
REQ-023 out_valid = 0, mono_out and check_err retain last value outside HOLD; in_valid ignored outside IDLE.
REQ-024 err_count SHALL increment by 1 on the CHECK->HOLD edge when check_err is set, saturating at 16'hFFFF.
REQ-025 err_clr SHALL zero err_count on the next edge; err_clr coincident with an increment: clear wins (result 0).
REQ-026 share inputs SHALL be treated as 15-bit XOR-shared values; no arithmetic carry, width fixed.

Reset
REQ-027 rst high SHALL immediately force state IDLE, in_ready = 1 after release, out_valid 0, mono_out 0, nibble_out 0, check_err 0, err_count 0, r0, r1, acc 0.
REQ-028 rst asserted mid-transaction (any non-IDLE state) SHALL discard the transaction with no out_valid pulse.

Verification
REQ-029 share0_in=0x1234, share1_in=0x4910, in_valid 1 cycle -> 3 clocks later out_valid=1, mono_out=0x5B24, nibble_out=0xB, check_err=0, err_count=0.
REQ-030 share0_in=0x7FFF, share1_in=0x0000 -> mono_out=0x7FFF, nibble_out=0xF, check_err=0; then share0_in=0x0400, share1_in=0x0000 -> check_err=1, err_count=1.
REQ-031 out_ready held 0 for 10 cycles in HOLD, in_valid=1 throughout -> outputs stable, in_ready=0, second pair accepted only the cycle after out_ready handshake.
REQ-032 rst pulsed while in MIX1 -> no out_valid, all outputs 0, next pair 0x1234/0x4910 produces 0x5B24 with normal 3-clock latency.
REQ-033 err_count preloaded to 0xFFFF by repeated error pairs -> stays 0xFFFF on further error; err_clr asserted on the CHECK->HOLD edge of an error result -> err_count=0.
REQ-034 CHECK_EN=0, share0_in=0x0400, share1_in=0 -> mono_out=0x0400, check_err=0, err_count=0.
